// File: rtl/gauss_jordan_inv_seq.sv
// gauss_jordan_inv_seq: sequential Gauss-Jordan inverse of an N x N signed
// Q(W-FRAC).FRAC matrix on an internal [A | B] register array, with one shared
// divider and one shared multiplier. Load and drain are valid/ready streams.
// Optional build macro GJ_PARTIAL_PIVOT_EN adds per-column max-magnitude row
// search and row swap ahead of each pivot.
//
// state  | meaning
// IDLE   | waiting for the first load beat
// LOAD   | accepting the remaining elements of A
// SEARCH | scan column k for the largest magnitude row (partial pivot build)
// SWAP   | exchange row k with the winning row, one column per cycle
// PIVOT  | reciprocal of A[k][k]; zero pivot aborts as singular
// NORM   | scale row k of A and B by the reciprocal
// ELIMF  | latch elimination factor A[i][k]
// ELIM   | row i -= factor * row k, across A then B
// DRAIN  | stream B row-major
module gauss_jordan_inv_seq #(
  parameter int N    = 5,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         singular
);
  localparam int RW = $clog2(N);
  localparam logic [RW-1:0] LAST  = RW'(N - 1);
  localparam logic [RW-1:0] LAST2 = RW'(N - 2);
  localparam logic signed [W-1:0] ONE_Q = W'(1 << FRAC);
  localparam logic signed [2*W-1:0] DIV_NUM = (2*W)'(1) << (2*FRAC);
  localparam logic signed [2*W-1:0] DEN_ONE = (2*W)'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SEARCH, S_SWAP, S_PIVOT, S_NORM, S_ELIMF, S_ELIM, S_DRAIN
  } state_t;

`ifdef GJ_PARTIAL_PIVOT_EN
  localparam state_t S_COL = S_SEARCH;
`else
  localparam state_t S_COL = S_PIVOT;
`endif

  state_t state, state_nx;

  logic signed [W-1:0] a [N][N];
  logic signed [W-1:0] b [N][N];
  logic [RW-1:0] k, row, col;
  logic half;
  logic signed [W-1:0] recip, fac;

  logic signed [W-1:0] piv, piv_el, cur_el, mul_x, mul_y, mul_res, recip_nx;
  logic signed [2*W-1:0] prod, den;
  logic in_fire, out_fire, row_end, last_row, load_last;
  logic [RW-1:0] next_row;

  assign in_ready  = (state == S_IDLE) || (state == S_LOAD);
  assign out_valid = (state == S_DRAIN);
  assign busy      = (state != S_IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? b[row][col] : '0;
  assign out_last  = out_valid && (row == LAST) && (col == LAST);
  assign load_last = (state == S_LOAD) && in_fire && (row == LAST) && (col == LAST);

  // Shared datapath: NORM scales row k by recip, ELIM forms factor * row k.
  assign piv     = a[k][k];
  assign piv_el  = half ? b[k][col] : a[k][col];
  assign cur_el  = half ? b[row][col] : a[row][col];
  assign mul_x   = (state == S_NORM) ? piv_el : fac;
  assign mul_y   = (state == S_NORM) ? recip : piv_el;
  assign prod    = {{W{mul_x[W-1]}}, mul_x} * {{W{mul_y[W-1]}}, mul_y};
  assign mul_res = W'(prod >>> FRAC);
  // Divisor forced to 1 on a zero pivot; that quotient is never used.
  assign den      = (piv == '0) ? DEN_ONE : $signed({{W{piv[W-1]}}, piv});
  assign recip_nx = W'(DIV_NUM / den);

  assign row_end  = half && (col == LAST);
  assign last_row = (row == LAST) || ((row == LAST2) && (k == LAST));
  assign next_row = ((row + RW'(1)) == k) ? row + RW'(2) : row + RW'(1);

`ifdef GJ_PARTIAL_PIVOT_EN
  logic [RW-1:0] best, best_nx;
  logic [W-1:0] best_mag, cand_mag;
  logic signed [W-1:0] cand;
  logic cand_win;

  assign cand     = a[row][k];
  assign cand_mag = cand[W-1] ? W'(-cand) : W'(cand);
  assign cand_win = (row == k) || (cand_mag > best_mag);
  assign best_nx  = cand_win ? row : best;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (in_fire) state_nx = S_LOAD;
      S_LOAD:   if (load_last) state_nx = S_COL;
`ifdef GJ_PARTIAL_PIVOT_EN
      S_SEARCH: if (row == LAST) state_nx = (best_nx != k) ? S_SWAP : S_PIVOT;
      S_SWAP:   if (row_end) state_nx = S_PIVOT;
`endif
      S_PIVOT:  state_nx = (piv == '0) ? S_IDLE : S_NORM;
      S_NORM:   if (row_end) state_nx = S_ELIMF;
      S_ELIMF:  state_nx = S_ELIM;
      S_ELIM: begin
        if (row_end && last_row) state_nx = (k == LAST) ? S_DRAIN : S_COL;
        else if (row_end)        state_nx = S_ELIMF;
      end
      S_DRAIN:  if (out_fire && out_last) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Indices, reciprocal, factor and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= '0;
      row      <= '0;
      col      <= '0;
      half     <= 1'b0;
      recip    <= '0;
      fac      <= '0;
      done     <= 1'b0;
      singular <= 1'b0;
`ifdef GJ_PARTIAL_PIVOT_EN
      best     <= '0;
      best_mag <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (in_fire) begin
            if (state == S_IDLE) singular <= 1'b0;
            if (col == LAST) begin
              col <= '0;
              row <= (row == LAST) ? '0 : row + RW'(1);
            end else begin
              col <= col + RW'(1);
            end
            k    <= '0;
            half <= 1'b0;
          end
        end
`ifdef GJ_PARTIAL_PIVOT_EN
        S_SEARCH: begin
          best <= best_nx;
          if (cand_win) best_mag <= cand_mag;
          if (row != LAST) row <= row + RW'(1);
        end
        S_SWAP: begin
          if (col == LAST) begin col <= '0; half <= ~half; end
          else col <= col + RW'(1);
        end
`endif
        S_PIVOT: begin
          recip <= recip_nx;
          if (piv == '0) begin
            singular <= 1'b1;
            done     <= 1'b1;
            row      <= '0;
            col      <= '0;
            k        <= '0;
          end
        end
        S_NORM: begin
          if (col == LAST) begin col <= '0; half <= ~half; end
          else col <= col + RW'(1);
          if (row_end) row <= (k == '0) ? RW'(1) : '0;
        end
        S_ELIMF: fac <= a[row][k];
        S_ELIM: begin
          if (col == LAST) begin col <= '0; half <= ~half; end
          else col <= col + RW'(1);
          if (row_end) begin
            if (last_row) begin
              k   <= (k == LAST) ? '0 : k + RW'(1);
              row <= (k == LAST) ? '0 : k + RW'(1);
            end else begin
              row <= next_row;
            end
          end
        end
        S_DRAIN: begin
          if (out_fire) begin
            if (col == LAST) begin
              col <= '0;
              row <= (row == LAST) ? '0 : row + RW'(1);
            end else begin
              col <= col + RW'(1);
            end
            if (out_last) done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Augmented array writes; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE, S_LOAD: begin
        if (in_fire) a[row][col] <= in_data;
        if (load_last)
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              b[i][j] <= (i == j) ? ONE_Q : '0;
      end
`ifdef GJ_PARTIAL_PIVOT_EN
      S_SWAP: begin
        if (half) begin
          b[k][col]    <= b[best][col];
          b[best][col] <= b[k][col];
        end else begin
          a[k][col]    <= a[best][col];
          a[best][col] <= a[k][col];
        end
      end
`endif
      S_NORM: begin
        if (half) b[k][col] <= mul_res;
        else      a[k][col] <= mul_res;
      end
      S_ELIM: begin
        if (half) b[row][col] <= cur_el - mul_res;
        else      a[row][col] <= cur_el - mul_res;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_gauss_jordan_inv_seq.sv
// tb_gauss_jordan_inv_seq: directed bench for gauss_jordan_inv_seq (N=5, Q16.16).
// The 2x2 cases are embedded in the top-left corner of a 5x5 matrix whose
// remaining block is identity, so the inverse is block-diagonal.
module tb_gauss_jordan_inv_seq;
  localparam int N = 5;
  localparam int W = 32;
  localparam int FRAC = 16;
  localparam int NN = N * N;
  localparam logic [W-1:0] ONE = 32'h0001_0000;
`ifdef GJ_PARTIAL_PIVOT_EN
  localparam int EXP_LAT = 275 + 15;
  localparam int SING_BOUND = 111 + 12;
`else
  localparam int EXP_LAT = 275;
  localparam int SING_BOUND = 111;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_last, busy, done, singular;
  logic [W-1:0] in_data, out_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_load = 0;
  int done_cnt = 0;
  int out_cnt = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           tol;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  logic [W-1:0] mat [NN];
  logic [W-1:0] res [NN];
  int tolv = 0;

  logic stalled = 1'b0;
  logic exp_done = 1'b0;
  logic prev_done = 1'b0;
  logic [W-1:0] held_d;
  logic held_l;

  gauss_jordan_inv_seq #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .singular(singular)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_near(input string tag, input logic signed [W-1:0] obs,
                          input logic signed [W-1:0] expv, input int tol);
    int d;
    d = int'(obs) - int'(expv);
    if (d < 0) d = -d;
    total++;
    assert (!$isunknown(obs) && d <= tol) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, expv, tol);
    end
  endtask

  // Output monitor: scoreboard pop, stall stability, done timing.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      stalled = 1'b0;
      exp_done = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held_d);
        chk("stall_last", out_last, held_l);
      end
      if (prev_done) chk("done_one_cycle", done, 0);
      if (exp_done) begin
        chk("done_after_last", done, 1);
        chk("busy_after_done", busy, 0);
        exp_done = 1'b0;
      end
      prev_done = (done === 1'b1);
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        chk("done_vs_handshake", done, 0);
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          cur = sb.pop_front();
          if (cur.tol == 0) chk($sformatf("out_data[%0d]", out_cnt), out_data, cur.data);
          else chk_near($sformatf("out_near[%0d]", out_cnt), out_data, cur.data, cur.tol);
          chk($sformatf("out_last[%0d]", out_cnt), out_last, cur.last);
          if (out_last === 1'b1) exp_done = 1'b1;
        end
        out_cnt++;
      end
      stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
      held_d = out_data;
      held_l = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ident();
    for (int e = 0; e < NN; e++) begin
      mat[e] = (e / N == e % N) ? ONE : '0;
      res[e] = mat[e];
    end
    tolv = 0;
  endtask

  task automatic load(input bit push, input bit junk);
    for (int e = 0; e < NN; e++) begin
      if (e == 7) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data = mat[e];
      if (e == 0) chk("in_ready_idle", in_ready, 1);
      tick();
      if (e == 0) begin
        chk("busy_first_beat", busy, 1);
        chk("singular_cleared", singular, 0);
      end
    end
    t_load = cyc;
    chk("in_ready_compute", in_ready, 0);
    if (junk) begin
      in_data = 32'hDEAD_BEEF;
      repeat (3) tick();
    end
    in_valid = 1'b0;
    if (push)
      for (int e = 0; e < NN; e++)
        sb.push_back('{data: res[e], last: (e == NN - 1), tol: tolv});
  endtask

  task automatic wait_out(input string tag, input bit check_lat);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < EXP_LAT + 40) begin
      tick();
      n++;
    end
    chk({tag, "_out_valid_seen"}, out_valid, 1);
    if (check_lat) chk({tag, "_latency"}, cyc - t_load, EXP_LAT);
  endtask

  task automatic drain(input logic [3:0] pat, input string tag);
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 600) begin
      out_ready = pat[n % 4];
      tick();
      n++;
    end
    chk({tag, "_done_count"}, done_cnt - d0, 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_in_ready_after"}, in_ready, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic rst_check(input string tag);
    rst = 1'b1;
    tick();
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_done"}, done, 0);
    sb.delete();
    rst = 1'b0;
    tick();
    chk({tag, "_done_next"}, done, 0);
    chk({tag, "_out_valid_next"}, out_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_singular", singular, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b0;
    tick();

    // Identity with junk on in_valid during compute, full-rate drain.
    set_ident();
    out_ready = 1'b1;
    load(1, 1);
    wait_out("ident", 1);
    drain(4'b1111, "ident");

    // Diagonal 2, 4, 8, 16, 0.5.
    set_ident();
    mat[0]  = 32'h0002_0000; res[0]  = 32'h0000_8000;
    mat[6]  = 32'h0004_0000; res[6]  = 32'h0000_4000;
    mat[12] = 32'h0008_0000; res[12] = 32'h0000_2000;
    mat[18] = 32'h0010_0000; res[18] = 32'h0000_1000;
    mat[24] = 32'h0000_8000; res[24] = 32'h0002_0000;
    load(1, 0);
    drain(4'b1111, "diag");

    // Row 2 all zeros: singular abort by column 2, nothing drained.
    set_ident();
    mat[12] = '0;
    load(0, 0);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("sing_done", done, 1);
    chk("sing_flag", singular, 1);
    chk("sing_busy", busy, 0);
    chk("sing_by_col2", (n <= SING_BOUND), 1);
    repeat (3) tick();
    chk("sing_hold", singular, 1);

    // Dense [[4,7],[2,6]] block, stalls via out_ready 1-0-0-1.
    set_ident();
    mat[0] = 32'h0004_0000; mat[1] = 32'h0007_0000;
    mat[5] = 32'h0002_0000; mat[6] = 32'h0006_0000;
    res[0] = $rtoi(0.6 * 65536.0);
    res[1] = $rtoi(-0.7 * 65536.0);
    res[5] = $rtoi(-0.2 * 65536.0);
    res[6] = $rtoi(0.4 * 65536.0);
    tolv = 4;
    load(1, 0);
    drain(4'b1001, "dense");

    // Reset mid-ELIM, then a fresh identity.
    set_ident();
    out_ready = 1'b1;
    load(0, 0);
    repeat (20) tick();
    rst_check("rst_elim");
    load(1, 0);
    wait_out("post_rst_elim", 1);
    drain(4'b1111, "post_rst_elim");

    // Reset mid-DRAIN, then a fresh identity.
    set_ident();
    out_ready = 1'b1;
    load(1, 0);
    wait_out("pre_rst_drain", 0);
    repeat (5) tick();
    rst_check("rst_drain");
    load(1, 0);
    drain(4'b1111, "post_rst_drain");

    // Permutation [[0,1],[1,0]] block.
    set_ident();
    mat[0] = '0; mat[1] = ONE;
    mat[5] = ONE; mat[6] = '0;
    res[0] = '0; res[1] = ONE;
    res[5] = ONE; res[6] = '0;
`ifdef GJ_PARTIAL_PIVOT_EN
    load(1, 0);
    drain(4'b1111, "perm");
    chk("perm_not_singular", singular, 0);
`else
    load(0, 0);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("perm_done", done, 1);
    chk("perm_singular", singular, 1);
    chk("perm_col0", (n <= 1), 1);
`endif
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gauss_jordan_inv_seq.md
Name: gauss_jordan_inv_seq

Overview:
- Sequential, parametrised successor to the combinational 5x5 inverse datapath.
- Computes the inverse of an N x N signed fixed-point matrix by Gauss-Jordan elimination on an internal augmented register array [A | I].
- Uses one shared divider and one multiplier, time-multiplexed.
- Matrix is loaded and results are drained over valid/ready streams, row-major. Adds singular detection and back-pressure.

Parameters:
- N, 5, matrix dimension (2..8).
- W, 32, element width, signed two's complement.
- FRAC, 16, fractional bits (Q(W-FRAC).FRAC).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  load element valid.
- in_ready  out  1  high in IDLE/LOAD only.
- in_data  in  W  element of A, row-major (a00, a01, ...).
- out_valid  out  1  result element valid.
- out_ready  in  1  downstream accept.
- out_data  out  W  element of inverse, row-major.
- out_last  out  1  marks element (N-1, N-1).
- busy  out  1  high from first accepted load beat until done.
- done  out  1  one-cycle pulse at end of drain or at singular abort.
- singular  out  1  zero pivot found; held until next load beat accepted.

Behaviour:
- Reset: rst sampled on clk edge; all outputs 0 except in_ready=1. FSM to IDLE; counters cleared; array contents don't-care. Reset mid-compute or mid-drain aborts immediately; no done pulse.
- Load:
  - Beat accepted when in_valid & in_ready.
  - First beat clears singular and sets busy.
  - Beat N*N-1 moves FSM to COMPUTE next cycle; B is initialised to identity (diagonal = 1<<FRAC).
- States: IDLE -> LOAD -> PIVOT -> NORM -> ELIM -> (next column: PIVOT | all done: DRAIN) -> IDLE.
- PIVOT (1 cycle):
  - p = A[k][k]. If p == 0: singular=1, done=1, go to IDLE; nothing is drained.
  - Otherwise r = (1<<(2*FRAC)) / p, signed, truncated toward zero, result kept to W bits.
- NORM (2N cycles): one element per cycle, A[k][0..N-1] then B[k][0..N-1], each x := fx_mul(x, r).
- ELIM: for each row i != k, ascending:
  - 1 cycle latches f = A[i][k].
  - Then 2N cycles: A[i][j] -= fx_mul(f, A[k][j]), then B[i][j] likewise.
- fx_mul(a, b): full 2W signed product, arithmetic shift right FRAC, truncate to W. No saturation; wrap is permitted.
- Latency per column: 1 + 2N + (N-1)(1+2N). For N=5 that is 55 cycles, 275 total from the cycle after the last load beat to the first DRAIN cycle.
- DRAIN:
  - out_valid=1; out_data = B row-major.
  - Advances only on out_valid & out_ready. out_data/out_last stable while stalled.
  - After the last beat is accepted: done=1 for that cycle's successor, busy=0, FSM to IDLE.
- in_valid during COMPUTE/DRAIN is ignored (in_ready=0).
- done and the last handshake never coincide. done asserts the cycle after the out_last transfer.

Optional Feature:
- Macro: GJ_PARTIAL_PIVOT_EN.
- Defined:
  - PIVOT is preceded by SEARCH: N-k cycles scanning |A[i][k]| for i = k..N-1. The first maximum wins ties.
  - If the winner row != k, SWAP takes 2N cycles, exchanging rows in A and B one column per cycle. Otherwise SWAP is skipped (0 cycles).
  - Singular only if the maximum magnitude is 0.
- Undefined: no SEARCH/SWAP; pivot is A[k][k] directly; latency exactly as above.

Test Plan:
- Identity load (diag 0x00010000, off-diag 0), out_ready=1 -> 25 outputs identical to input; out_last on beat 24; done 1 cycle later; busy low after done; 275 cycles to first out_valid (macro off).
- diag(2,4,8,16,0.5) i.e. 0x20000, 0x40000, 0x80000, 0x100000, 0x8000 -> diagonal 0x8000, 0x4000, 0x2000, 0x1000, 0x20000; off-diag 0.
- Row 2 all zeros -> singular=1 and done pulse no later than column 2 PIVOT; out_valid never asserts; next load beat clears singular.
- Dense [[4,7],[2,6]] in Q16 with N=2 -> [[0.6,-0.7],[-0.2,0.4]] within 4 LSB. Toggle out_ready 1-0-0-1 -> data and out_last held stable during stalls; no element lost or duplicated.
- rst asserted mid-ELIM and mid-DRAIN -> next cycle out_valid=0, busy=0, in_ready=1, no done. Fresh identity load afterwards -> correct result.
- Permutation [[0,1],[1,0]] (N=2): with GJ_PARTIAL_PIVOT_EN -> inverse equals input, singular=0. Without -> singular=1 at column 0.
